// File: rtl/icache_pkg.sv
// Shared widths, FSM state encoding and word-select helper for the instruction cache.
package icache_pkg;

  localparam int ADDR_W   = 32;
  localparam int WORD_W   = 32;
  localparam int LINE_W   = 128;
  localparam int OFFSET_W = 4;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;
  localparam logic [1:0] ST_FILL = 2'd3;

  // Word k of a line lives in bits [32k+31:32k].
  function automatic logic [WORD_W-1:0] select_word(input logic [LINE_W-1:0] line,
                                                   input logic [1:0]        sel);
    return line[int'(sel)*WORD_W +: WORD_W];
  endfunction

endpackage

// File: rtl/icache_line_store.sv
// Tag/valid/data storage for the direct-mapped instruction cache.
// One fill write port, combinational read, flush clears every valid bit.
module icache_line_store
  import icache_pkg::*;
#(
  parameter int NUM_LINES = 4,
  parameter int INDEX_W   = 2,
  parameter int TAG_W     = 26
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               i_flush,
  input  logic               i_we,
  input  logic               i_we_valid,
  input  logic [INDEX_W-1:0] i_wr_index,
  input  logic [TAG_W-1:0]   i_wr_tag,
  input  logic [LINE_W-1:0]  i_wr_data,
  input  logic [INDEX_W-1:0] i_rd_index,
  output logic               o_rd_valid,
  output logic [TAG_W-1:0]   o_rd_tag,
  output logic [LINE_W-1:0]  o_rd_data
);

  logic [NUM_LINES-1:0] r_valid;
  logic [TAG_W-1:0]     r_tag  [NUM_LINES];
  logic [LINE_W-1:0]    r_data [NUM_LINES];

  // Flush takes priority over a fill landing on the same edge.
  generate
    for (genvar gi = 0; gi < NUM_LINES; gi++) begin : g_valid
      always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
          r_valid[gi] <= 1'b0;
        end else if (i_flush) begin
          r_valid[gi] <= 1'b0;
        end else if (i_we && (i_wr_index == INDEX_W'(gi))) begin
          r_valid[gi] <= i_we_valid;
        end
      end
    end
  endgenerate

  always_ff @(posedge clock) begin
    if (i_we) begin
      r_tag[i_wr_index]  <= i_wr_tag;
      r_data[i_wr_index] <= i_wr_data;
    end
  end

  assign o_rd_valid = r_valid[i_rd_index];
  assign o_rd_tag   = r_tag[i_rd_index];
  assign o_rd_data  = r_data[i_rd_index];

endmodule

// File: rtl/icache_fill_ctrl.sv
// Direct-mapped instruction cache with a single-outstanding miss engine toward instruction_mem.
// Define ICACHE_STATS_EN to add the hit_count/miss_count outputs.
module icache_fill_ctrl
  import icache_pkg::*;
#(
  parameter int NUM_LINES = 4
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  input  logic              flush,
  output logic [WORD_W-1:0] fetch_instr,
  output logic              fetch_valid,
  output logic              mem_enable,
  output logic [ADDR_W-1:0] mem_address,
  input  logic [LINE_W-1:0] mem_data,
  input  logic              mem_valid
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0]       hit_count,
  output logic [31:0]       miss_count
`endif
);

  localparam int INDEX_W = $clog2(NUM_LINES);
  localparam int TAG_W   = ADDR_W - OFFSET_W - INDEX_W;
  localparam int LADDR_W = ADDR_W - OFFSET_W;

  logic [1:0]         r_state;
  logic               r_mem_enable;
  logic [LADDR_W-1:0] r_line_addr;
  logic [1:0]         r_word_sel;
  logic               r_req_live;
  logic               r_flushed;
  logic               r_fetch_valid;
  logic [WORD_W-1:0]  r_fetch_instr;

  logic [INDEX_W-1:0] w_rd_index;
  logic [TAG_W-1:0]   w_req_tag;
  logic [1:0]         w_word_sel;
  logic               w_line_valid;
  logic [TAG_W-1:0]   w_line_tag;
  logic [LINE_W-1:0]  w_line_data;
  logic               w_in_miss;
  logic               w_hit;
  logic               w_miss;
  logic               w_fill;
  logic               w_fill_valid;
  logic               w_unused;

  assign w_rd_index = fetch_addr[OFFSET_W +: INDEX_W];
  assign w_req_tag  = fetch_addr[ADDR_W-1 -: TAG_W];
  assign w_word_sel = fetch_addr[3:2];
  assign w_unused   = &{1'b0, fetch_addr[1:0]};

  // A flush on the lookup edge forces a miss so stale data is never returned.
  assign w_hit     = (r_state == ST_IDLE) && fetch_req && !flush &&
                     w_line_valid && (w_line_tag == w_req_tag);
  assign w_miss    = (r_state == ST_IDLE) && fetch_req && !w_hit;
  assign w_fill    = (r_state == ST_WAIT) && mem_valid;
  assign w_in_miss = (r_state == ST_REQ) || (r_state == ST_WAIT);
  // A flush seen at any point during the miss leaves the filled line invalid.
  assign w_fill_valid = !(flush || r_flushed);

  icache_line_store #(
    .NUM_LINES (NUM_LINES),
    .INDEX_W   (INDEX_W),
    .TAG_W     (TAG_W)
  ) u_line_store (
    .clock      (clock),
    .reset_n    (reset_n),
    .i_flush    (flush),
    .i_we       (w_fill),
    .i_we_valid (w_fill_valid),
    .i_wr_index (r_line_addr[INDEX_W-1:0]),
    .i_wr_tag   (r_line_addr[LADDR_W-1 -: TAG_W]),
    .i_wr_data  (mem_data),
    .i_rd_index (w_rd_index),
    .o_rd_valid (w_line_valid),
    .o_rd_tag   (w_line_tag),
    .o_rd_data  (w_line_data)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= ST_IDLE;
      r_mem_enable  <= 1'b0;
      r_line_addr   <= '0;
      r_word_sel    <= '0;
      r_req_live    <= 1'b0;
      r_flushed     <= 1'b0;
      r_fetch_valid <= 1'b0;
      r_fetch_instr <= '0;
    end else begin
      r_fetch_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_hit) begin
            r_fetch_valid <= 1'b1;
            r_fetch_instr <= select_word(w_line_data, w_word_sel);
          end else if (w_miss) begin
            r_state      <= ST_REQ;
            r_mem_enable <= 1'b1;
            r_line_addr  <= fetch_addr[ADDR_W-1:OFFSET_W];
            r_word_sel   <= w_word_sel;
            r_req_live   <= 1'b1;
            r_flushed    <= 1'b0;
          end
        end
        ST_REQ: begin
          r_state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (mem_valid) begin
            r_state      <= ST_FILL;
            r_mem_enable <= 1'b0;
            // The line is always written; delivery only if fetch still wants it.
            if (r_req_live && fetch_req) begin
              r_fetch_valid <= 1'b1;
              r_fetch_instr <= select_word(mem_data, r_word_sel);
            end
          end
        end
        ST_FILL: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state      <= ST_IDLE;
          r_mem_enable <= 1'b0;
        end
      endcase
      if (w_in_miss && !fetch_req) begin
        r_req_live <= 1'b0;
      end
      if (w_in_miss && flush) begin
        r_flushed <= 1'b1;
      end
    end
  end

  assign fetch_valid = r_fetch_valid;
  assign fetch_instr = r_fetch_instr;
  assign mem_enable  = r_mem_enable;
  assign mem_address = {r_line_addr, {OFFSET_W{1'b0}}};

`ifdef ICACHE_STATS_EN
  logic [31:0] r_hit_count;
  logic [31:0] r_miss_count;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_hit_count  <= '0;
      r_miss_count <= '0;
    end else begin
      if (w_hit) begin
        r_hit_count <= r_hit_count + 32'd1;
      end
      if (w_miss) begin
        r_miss_count <= r_miss_count + 32'd1;
      end
    end
  end

  assign hit_count  = r_hit_count;
  assign miss_count = r_miss_count;
`endif

endmodule

// File: tb/tb_icache_fill_ctrl.sv
// Directed bench for icache_fill_ctrl: reset, misses, hits, conflicts, flush, reset mid-miss, dropped request.
`timescale 1ns/1ps
module tb_icache_fill_ctrl;

  localparam int PERIOD = 10;

  logic         clock       = 1'b0;
  logic         reset_n     = 1'b0;
  logic         fetch_req   = 1'b0;
  logic [31:0]  fetch_addr  = '0;
  logic         flush       = 1'b0;
  logic [31:0]  fetch_instr;
  logic         fetch_valid;
  logic         mem_enable;
  logic [31:0]  mem_address;
  logic [127:0] mem_data    = '0;
  logic         mem_valid   = 1'b0;
`ifdef ICACHE_STATS_EN
  logic [31:0]  hit_count;
  logic [31:0]  miss_count;
`endif

  int pass_cnt = 0;
  int chk_cnt  = 0;

  // Memory responder state
  int          mem_latency   = 10;
  bit          spur_valid    = 1'b0;
  bit          mem_busy      = 1'b0;
  int          mem_cnt       = 0;
  logic [31:0] mem_seen_addr = '0;
  int          mem_rises     = 0;
  time         mem_pulse_time = 0;
  bit          prev_en       = 1'b0;
  int          fv_pulses     = 0;

  always #(PERIOD/2) clock = ~clock;

  icache_fill_ctrl #(.NUM_LINES(4)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .fetch_req   (fetch_req),
    .fetch_addr  (fetch_addr),
    .flush       (flush),
    .fetch_instr (fetch_instr),
    .fetch_valid (fetch_valid),
    .mem_enable  (mem_enable),
    .mem_address (mem_address),
    .mem_data    (mem_data),
    .mem_valid   (mem_valid)
`ifdef ICACHE_STATS_EN
    ,
    .hit_count   (hit_count),
    .miss_count  (miss_count)
`endif
  );

  // Memory word at byte address a is 0xC0DE0000 + a.
  function automatic logic [127:0] make_block(input logic [31:0] a);
    logic [127:0] b;
    logic [31:0]  base;
    base = 32'hC0DE0000 + {a[31:4], 4'h0};
    for (int k = 0; k < 4; k++) b[32*k +: 32] = base + 32'(4*k);
    return b;
  endfunction

  // Responds to each mem_enable rising edge with one mem_valid pulse mem_latency cycles later.
  always @(negedge clock) begin
    mem_valid = spur_valid;
    if (fetch_valid === 1'b1) fv_pulses++;
    if (!reset_n) begin
      mem_busy = 1'b0;
    end else if (mem_busy) begin
      mem_cnt--;
      if (mem_cnt <= 0) begin
        mem_busy       = 1'b0;
        mem_valid      = 1'b1;
        mem_data       = make_block(mem_seen_addr);
        mem_pulse_time = $time;
      end
    end
    if (reset_n && mem_enable === 1'b1 && !prev_en) begin
      mem_busy      = 1'b1;
      mem_cnt       = mem_latency;
      mem_seen_addr = mem_address;
      mem_rises++;
    end
    prev_en = (mem_enable === 1'b1);
  end

  task automatic sync();
    @(posedge clock);
    #1;
  endtask

  task automatic do_fetch(input logic [31:0] addr, output bit got, output logic [31:0] instr,
                          output int lat, output time vtime);
    got = 1'b0; instr = '0; lat = 0; vtime = 0;
    fetch_addr = addr;
    fetch_req  = 1'b1;
    for (int c = 1; c <= 200; c++) begin
      @(posedge clock);
      @(negedge clock);
      if (fetch_valid === 1'b1) begin
        got = 1'b1; instr = fetch_instr; lat = c; vtime = $time;
        break;
      end
    end
    fetch_req = 1'b0;
  endtask

  task automatic wait_mem_enable(output bit seen);
    seen = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clock);
      if (mem_enable === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; fetch_req = 1'b0; flush = 1'b0;
    repeat (3) @(negedge clock);
    chk_cnt++; if (fetch_valid !== 1'b0) $display("FAIL reset_fetch_valid: got %b expected 0", fetch_valid); else pass_cnt++;
    chk_cnt++; if (fetch_instr !== 32'h0) $display("FAIL reset_fetch_instr: got %h expected 00000000", fetch_instr); else pass_cnt++;
    chk_cnt++; if (mem_enable !== 1'b0) $display("FAIL reset_mem_enable: got %b expected 0", mem_enable); else pass_cnt++;
    chk_cnt++; if (mem_address !== 32'h0) $display("FAIL reset_mem_address: got %h expected 00000000", mem_address); else pass_cnt++;
    sync();
    reset_n = 1'b1;
    $display("reset: fetch_valid=%b mem_enable=%b mem_address=%h", fetch_valid, mem_enable, mem_address);
  endtask

  task automatic test_spurious();
    int  r0, p0;
    bit  en_seen;
    r0 = mem_rises; p0 = fv_pulses; en_seen = 1'b0;
    repeat (9) sync();
    spur_valid = 1'b1;
    sync();
    spur_valid = 1'b0;
    repeat (5) begin
      @(negedge clock);
      if (mem_enable === 1'b1) en_seen = 1'b1;
    end
    chk_cnt++; if (fv_pulses - p0 !== 0) $display("FAIL spur_fetch_valid: got %0d pulses expected 0", fv_pulses - p0); else pass_cnt++;
    chk_cnt++; if (en_seen !== 1'b0) $display("FAIL spur_mem_enable: got %b expected 0", en_seen); else pass_cnt++;
    chk_cnt++; if (mem_rises - r0 !== 0) $display("FAIL spur_requests: got %0d expected 0", mem_rises - r0); else pass_cnt++;
    $display("spurious mem_valid: pulses=%0d requests=%0d", fv_pulses - p0, mem_rises - r0);
  endtask

  task automatic test_cold_miss();
    bit got; logic [31:0] instr; int lat; time vt; int r0, p0;
    mem_latency = 10;
    sync();
    r0 = mem_rises; p0 = fv_pulses;
    do_fetch(32'h0000_0008, got, instr, lat, vt);
    chk_cnt++; if (got !== 1'b1) $display("FAIL cold_got: got %b expected 1", got); else pass_cnt++;
    chk_cnt++; if (instr !== 32'hC0DE0008) $display("FAIL cold_instr: got %h expected C0DE0008", instr); else pass_cnt++;
    chk_cnt++; if (mem_rises - r0 !== 1) $display("FAIL cold_requests: got %0d expected 1", mem_rises - r0); else pass_cnt++;
    chk_cnt++; if (mem_seen_addr !== 32'h0) $display("FAIL cold_mem_address: got %h expected 00000000", mem_seen_addr); else pass_cnt++;
    chk_cnt++; if ((vt - mem_pulse_time) !== 64'(PERIOD)) $display("FAIL cold_delay: got %0t expected %0d after mem_valid", vt - mem_pulse_time, PERIOD); else pass_cnt++;
    repeat (3) @(negedge clock);
    chk_cnt++; if (fv_pulses - p0 !== 1) $display("FAIL cold_pulses: got %0d expected 1", fv_pulses - p0); else pass_cnt++;
    chk_cnt++; if (mem_enable !== 1'b0) $display("FAIL cold_enable_low: got %b expected 0", mem_enable); else pass_cnt++;
    $display("cold miss 0x8: instr=%h latency=%0d", instr, lat);
  endtask

  task automatic test_hit();
    bit got; logic [31:0] instr; int lat; time vt; int r0;
    sync();
    r0 = mem_rises;
    do_fetch(32'h0000_000C, got, instr, lat, vt);
    chk_cnt++; if (got !== 1'b1) $display("FAIL hit_got: got %b expected 1", got); else pass_cnt++;
    chk_cnt++; if (lat !== 1) $display("FAIL hit_latency: got %0d expected 1", lat); else pass_cnt++;
    chk_cnt++; if (instr !== 32'hC0DE000C) $display("FAIL hit_instr: got %h expected C0DE000C", instr); else pass_cnt++;
    chk_cnt++; if (mem_rises - r0 !== 0) $display("FAIL hit_requests: got %0d expected 0", mem_rises - r0); else pass_cnt++;
    $display("hit 0xC: instr=%h latency=%0d", instr, lat);
  endtask

  task automatic test_back_to_back();
    int r0;
    logic [31:0] exp;
    sync();
    r0 = mem_rises;
    fetch_addr = 32'h0; fetch_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      sync();
      exp = 32'hC0DE0000 + 32'(4*i);
      chk_cnt++; if (fetch_valid !== 1'b1) $display("FAIL b2b_valid[%0d]: got %b expected 1", i, fetch_valid); else pass_cnt++;
      chk_cnt++; if (fetch_instr !== exp) $display("FAIL b2b_instr[%0d]: got %h expected %h", i, fetch_instr, exp); else pass_cnt++;
      $display("back-to-back word %0d: instr=%h", i, fetch_instr);
      if (i < 3) fetch_addr = 32'(4*(i+1));
      else fetch_req = 1'b0;
    end
    sync();
    chk_cnt++; if (fetch_valid !== 1'b0) $display("FAIL b2b_tail: got %b expected 0", fetch_valid); else pass_cnt++;
    chk_cnt++; if (mem_rises - r0 !== 0) $display("FAIL b2b_requests: got %0d expected 0", mem_rises - r0); else pass_cnt++;
  endtask

  task automatic test_conflict();
    bit got; logic [31:0] instr; int lat; time vt; int r0;
    mem_latency = 3;
    sync();
    r0 = mem_rises;
    do_fetch(32'h0000_0040, got, instr, lat, vt);
    chk_cnt++; if (instr !== 32'hC0DE0040) $display("FAIL conf_a_instr: got %h expected C0DE0040", instr); else pass_cnt++;
    chk_cnt++; if (mem_seen_addr !== 32'h40) $display("FAIL conf_a_addr: got %h expected 00000040", mem_seen_addr); else pass_cnt++;
    chk_cnt++; if (mem_rises - r0 !== 1) $display("FAIL conf_a_requests: got %0d expected 1", mem_rises - r0); else pass_cnt++;
    $display("conflict fill 0x40: instr=%h", instr);
    sync();
    do_fetch(32'h0000_0000, got, instr, lat, vt);
    chk_cnt++; if (mem_rises - r0 !== 2) $display("FAIL conf_b_requests: got %0d expected 2", mem_rises - r0); else pass_cnt++;
    chk_cnt++; if (instr !== 32'hC0DE0000) $display("FAIL conf_b_instr: got %h expected C0DE0000", instr); else pass_cnt++;
    $display("conflict refill 0x00: instr=%h", instr);
    sync();
    do_fetch(32'h0000_0004, got, instr, lat, vt);
    chk_cnt++; if (lat !== 1) $display("FAIL conf_hit_latency: got %0d expected 1", lat); else pass_cnt++;
    chk_cnt++; if (instr !== 32'hC0DE0004) $display("FAIL conf_hit_instr: got %h expected C0DE0004", instr); else pass_cnt++;
    $display("hit 0x04 after refill: instr=%h latency=%0d", instr, lat);
  endtask

  task automatic test_flush();
    bit got; logic [31:0] instr; int lat; time vt; int r0; bit seen;
    mem_latency = 8;
    sync();
    r0 = mem_rises;
    fork
      do_fetch(32'h0000_0010, got, instr, lat, vt);
      begin
        wait_mem_enable(seen);
        repeat (3) sync();
        flush = 1'b1;
        sync();
        flush = 1'b0;
      end
    join
    chk_cnt++; if (seen !== 1'b1) $display("FAIL flush_wait_enable: got %b expected 1", seen); else pass_cnt++;
    chk_cnt++; if (got !== 1'b1) $display("FAIL flush_wait_got: got %b expected 1", got); else pass_cnt++;
    chk_cnt++; if (instr !== 32'hC0DE0010) $display("FAIL flush_wait_instr: got %h expected C0DE0010", instr); else pass_cnt++;
    $display("flush during wait 0x10: instr=%h", instr);
    sync();
    do_fetch(32'h0000_0010, got, instr, lat, vt);
    chk_cnt++; if (mem_rises - r0 !== 2) $display("FAIL flush_refetch_requests: got %0d expected 2", mem_rises - r0); else pass_cnt++;
    chk_cnt++; if (instr !== 32'hC0DE0010) $display("FAIL flush_refetch_instr: got %h expected C0DE0010", instr); else pass_cnt++;
    $display("refetch 0x10 after flush: instr=%h requests=%0d", instr, mem_rises - r0);
    sync();
    flush = 1'b1;
    fork
      do_fetch(32'h0000_0014, got, instr, lat, vt);
      begin
        sync();
        flush = 1'b0;
      end
    join
    chk_cnt++; if (mem_rises - r0 !== 3) $display("FAIL flush_hit_requests: got %0d expected 3", mem_rises - r0); else pass_cnt++;
    chk_cnt++; if (instr !== 32'hC0DE0014) $display("FAIL flush_hit_instr: got %h expected C0DE0014", instr); else pass_cnt++;
    $display("flush with hit 0x14: instr=%h", instr);
    sync();
    do_fetch(32'h0000_0018, got, instr, lat, vt);
    chk_cnt++; if (lat !== 1) $display("FAIL flush_after_latency: got %0d expected 1", lat); else pass_cnt++;
    chk_cnt++; if (instr !== 32'hC0DE0018) $display("FAIL flush_after_instr: got %h expected C0DE0018", instr); else pass_cnt++;
    $display("hit 0x18: instr=%h latency=%0d", instr, lat);
  endtask

  task automatic test_reset_mid_miss();
    bit got; logic [31:0] instr; int lat; time vt; int r0, p0; bit seen;
    mem_latency = 10;
    sync();
    r0 = mem_rises;
    fetch_addr = 32'h0000_0020; fetch_req = 1'b1;
    wait_mem_enable(seen);
    chk_cnt++; if (seen !== 1'b1) $display("FAIL rst_mid_enable: got %b expected 1", seen); else pass_cnt++;
    repeat (2) @(negedge clock);
    reset_n = 1'b0;
    #1;
    chk_cnt++; if (mem_enable !== 1'b0) $display("FAIL rst_mid_drop: got %b expected 0", mem_enable); else pass_cnt++;
    fetch_req = 1'b0;
    repeat (2) @(negedge clock);
    sync();
    reset_n = 1'b1;
    p0 = fv_pulses;
    repeat (15) @(negedge clock);
    chk_cnt++; if (fv_pulses - p0 !== 0) $display("FAIL rst_mid_stale: got %0d pulses expected 0", fv_pulses - p0); else pass_cnt++;
    sync();
    do_fetch(32'h0000_0020, got, instr, lat, vt);
    chk_cnt++; if (got !== 1'b1) $display("FAIL rst_post_got: got %b expected 1", got); else pass_cnt++;
    chk_cnt++; if (instr !== 32'hC0DE0020) $display("FAIL rst_post_instr: got %h expected C0DE0020", instr); else pass_cnt++;
    chk_cnt++; if (mem_rises - r0 !== 2) $display("FAIL rst_post_requests: got %0d expected 2", mem_rises - r0); else pass_cnt++;
    $display("reset mid-miss then 0x20: instr=%h requests=%0d", instr, mem_rises - r0);
  endtask

  task automatic test_req_drop();
    bit got; logic [31:0] instr; int lat; time vt; int r0, p0; bit seen;
    mem_latency = 5;
    sync();
    r0 = mem_rises; p0 = fv_pulses;
    fetch_addr = 32'h0000_0030; fetch_req = 1'b1;
    wait_mem_enable(seen);
    fetch_req = 1'b0;
    repeat (15) @(negedge clock);
    chk_cnt++; if (fv_pulses - p0 !== 0) $display("FAIL drop_suppressed: got %0d pulses expected 0", fv_pulses - p0); else pass_cnt++;
    chk_cnt++; if (mem_rises - r0 !== 1) $display("FAIL drop_requests: got %0d expected 1", mem_rises - r0); else pass_cnt++;
    sync();
    do_fetch(32'h0000_003C, got, instr, lat, vt);
    chk_cnt++; if (lat !== 1) $display("FAIL drop_hit_latency: got %0d expected 1", lat); else pass_cnt++;
    chk_cnt++; if (instr !== 32'hC0DE003C) $display("FAIL drop_hit_instr: got %h expected C0DE003C", instr); else pass_cnt++;
    $display("dropped request 0x30 then hit 0x3C: instr=%h latency=%0d", instr, lat);
  endtask

  initial begin
    #(PERIOD * 20000);
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_spurious();
    test_cold_miss();
    test_hit();
    test_back_to_back();
    test_conflict();
    test_flush();
    test_reset_mid_miss();
    test_req_drop();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
